seven_loader: RTL and testbench

Sequencer that programs a 49-cell pattern into the 7x7 Game-of-Life core through the core's own button interface, then optionally starts play. It sits between a pattern source and the core's `in_stop`/`in_prgm`/`in_pp`/`in_btn0`/`in_btn1` inputs, driving them the way an operator does. It then reads back `out_grid` and `out_game_state` to confirm the load.

---
 rtl/seven_loader_pkg.sv | 28 ++
 rtl/seven_loader_hold_counter.sv | 35 +++
 rtl/seven_loader.sv | 206 ++++++++++++++++++++
 tb/tb_seven_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/seven_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seven_pkg
// Brief    : Shared constants and state encoding for the 7x7 pattern loader.
// Revision : 1.0
// ============================================================================
package seven_pkg;

   localparam logic [1:0] GS_STOP  = 2'b00;
   localparam logic [1:0] GS_PRGM  = 2'b01;
   localparam logic [1:0] GS_PLAY  = 2'b10;
   localparam logic [1:0] GS_PAUSE = 2'b11;

   localparam int N_CELLS_DEFAULT = 49;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_STOP   = 3'd1,
      ST_PRGM   = 3'd2,
      ST_WAIT   = 3'd3,
      ST_LOAD   = 3'd4,
      ST_SETTLE = 3'd5,
      ST_CHECK  = 3'd6,
      ST_PLAY   = 3'd7
   } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/seven_loader_hold_counter.sv
`default_nettype none
// ============================================================================
// Module   : hold_counter
// Brief    : Loadable down-counter with zero flag; saturates at zero.
// Revision : 1.0
// ============================================================================
module hold_counter #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic [WIDTH-1:0] count,
   output logic             zero
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign count = r_count;
   assign zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/seven_loader.sv
`default_nettype none
// ============================================================================
// Module   : seven_loader
// Brief    : Programs a pattern into the Game-of-Life core via its buttons.
// Revision : 1.0
// ============================================================================
module seven_loader
   import seven_pkg::*;
#(
   parameter int N_CELLS     = N_CELLS_DEFAULT,
   parameter int HOLD_CYCLES = 2,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic               in_clk,
   input  logic               in_rst_n,
   input  logic               in_start,
   input  logic [N_CELLS-1:0] in_pattern,
   input  logic               in_autoplay,
   input  logic [1:0]         in_game_state,
   input  logic [N_CELLS-1:0] in_grid,
   output logic               out_stop,
   output logic               out_prgm,
   output logic               out_pp,
   output logic               out_btn0,
   output logic               out_btn1,
   output logic               out_busy,
   output logic               out_done,
   output logic               out_error,
   output logic [5:0]         out_cell_idx
);

   localparam logic [5:0] c_hold_load = 6'(HOLD_CYCLES - 1);
   localparam logic [5:0] c_ack_load  = 6'(ACK_TIMEOUT);
   localparam logic [5:0] c_last_idx  = 6'(N_CELLS - 1);

   loader_state_t      r_state, w_state_nxt;
   logic [N_CELLS-1:0] r_pattern, w_pat_shift;
   logic               r_autoplay;
   logic [5:0]         r_idx, w_idx_nxt;
   logic               r_stop, r_prgm, r_pp, r_btn0, r_btn1;
   logic               r_busy, r_done, r_error;
   logic [5:0]         r_cell_idx;

   logic               w_cnt_load, w_cnt_dec, w_cnt_zero;
   logic [5:0]         w_cnt_val, w_cnt;
   logic               w_accept, w_fail, w_pp_nxt, w_cell_bit;

   hold_counter #(.WIDTH(6)) u_cnt (
      .clk      (in_clk),
      .rst_n    (in_rst_n),
      .load     (w_cnt_load),
      .load_val (w_cnt_val),
      .dec      (w_cnt_dec),
      .count    (w_cnt),
      .zero     (w_cnt_zero)
   );

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cnt_load  = 1'b0;
      w_cnt_val   = '0;
      w_cnt_dec   = 1'b0;
      w_accept    = 1'b0;
      w_fail      = 1'b0;
      w_pp_nxt    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // A start landing on the done cycle is dropped.
            if (in_start && !r_done) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_STOP;
               w_cnt_load  = 1'b1;
               w_cnt_val   = c_hold_load;
            end
         end
         ST_STOP: begin
            if (w_cnt_zero) begin
               w_state_nxt = ST_PRGM;
               w_cnt_load  = 1'b1;
               w_cnt_val   = c_hold_load;
            end else begin
               w_cnt_dec = 1'b1;
            end
         end
         ST_PRGM: begin
            if (w_cnt_zero) begin
               w_state_nxt = ST_WAIT;
               w_cnt_load  = 1'b1;
               w_cnt_val   = c_ack_load;
            end else begin
               w_cnt_dec = 1'b1;
            end
         end
         ST_WAIT: begin
            // First WAIT cycle lets the core register the prgm release.
            if ((w_cnt != c_ack_load) && (in_game_state == GS_PRGM)) begin
               w_state_nxt = ST_LOAD;
               w_idx_nxt   = '0;
            end else if (w_cnt_zero) begin
               w_state_nxt = ST_IDLE;
               w_fail      = 1'b1;
            end else begin
               w_cnt_dec = 1'b1;
            end
         end
         ST_LOAD: begin
            if (r_idx == c_last_idx) begin
               w_state_nxt = ST_SETTLE;
               w_cnt_load  = 1'b1;
               w_cnt_val   = c_hold_load;
            end else begin
               w_idx_nxt = r_idx + 6'd1;
            end
         end
         ST_SETTLE: begin
            if (w_cnt_zero) begin
               w_state_nxt = ST_CHECK;
            end else begin
               w_cnt_dec = 1'b1;
            end
         end
         ST_CHECK: begin
            if (in_grid != r_pattern) begin
               w_state_nxt = ST_IDLE;
               w_fail      = 1'b1;
            end else if (r_autoplay) begin
               w_state_nxt = ST_PLAY;
               w_cnt_load  = 1'b1;
               w_cnt_val   = 6'd1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_PLAY: begin
            // One quiet cycle after CHECK, then the play/pause pulse.
            if (w_cnt_zero) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_dec = 1'b1;
               w_pp_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_pat_shift = r_pattern >> w_idx_nxt;
   assign w_cell_bit  = w_pat_shift[0];

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_pattern  <= '0;
         r_autoplay <= 1'b0;
         r_idx      <= '0;
         r_stop     <= 1'b0;
         r_prgm     <= 1'b0;
         r_pp       <= 1'b0;
         r_btn0     <= 1'b0;
         r_btn1     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_cell_idx <= '0;
      end else begin
         if (w_accept) begin
            r_pattern  <= in_pattern;
            r_autoplay <= in_autoplay;
         end
         r_idx      <= w_idx_nxt;
         r_stop     <= (w_state_nxt == ST_STOP);
         r_prgm     <= (w_state_nxt == ST_PRGM);
         r_pp       <= w_pp_nxt;
         r_btn1     <= (w_state_nxt == ST_LOAD) && w_cell_bit;
         r_btn0     <= (w_state_nxt == ST_LOAD) && !w_cell_bit;
         r_cell_idx <= (w_state_nxt == ST_LOAD) ? w_idx_nxt : 6'd0;
         r_busy     <= (w_state_nxt != ST_IDLE);
         r_done     <= (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);
         if (w_accept) begin
            r_error <= 1'b0;
         end else if (w_fail) begin
            r_error <= 1'b1;
         end
      end
   end

   assign out_stop     = r_stop;
   assign out_prgm     = r_prgm;
   assign out_pp       = r_pp;
   assign out_btn0     = r_btn0;
   assign out_btn1     = r_btn1;
   assign out_busy     = r_busy;
   assign out_done     = r_done;
   assign out_error    = r_error;
   assign out_cell_idx = r_cell_idx;

endmodule
`default_nettype wire

// File: tb/tb_seven_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_loader
// Brief    : Self-checking bench for seven_loader (49/2/15 and 9/3/15 builds).
// Revision : 1.0
// ============================================================================
module tb_seven_loader;
   import seven_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       rst_n    = '0;
   logic [1:0]       start    = '0;
   logic [1:0]       autoplay = '0;
   logic [1:0][48:0] pattern  = '0;
   logic [1:0][48:0] grid     = '0;
   logic [1:0][1:0]  gs       = '0;
   logic [1:0]       ack_en   = '1;
   logic [1:0]       corrupt  = '0;
   int               cursor [2];

   wire [1:0]      stop, prgm, pp, btn0, btn1, busy, done, err;
   wire [1:0][5:0] idx;

   int errors = 0;
   int checks = 0;

   seven_loader u_big (
      .in_clk(clk), .in_rst_n(rst_n[0]), .in_start(start[0]),
      .in_pattern(pattern[0]), .in_autoplay(autoplay[0]),
      .in_game_state(gs[0]), .in_grid(grid[0]),
      .out_stop(stop[0]), .out_prgm(prgm[0]), .out_pp(pp[0]),
      .out_btn0(btn0[0]), .out_btn1(btn1[0]), .out_busy(busy[0]),
      .out_done(done[0]), .out_error(err[0]), .out_cell_idx(idx[0])
   );

   seven_loader #(.N_CELLS(9), .HOLD_CYCLES(3), .ACK_TIMEOUT(15)) u_small (
      .in_clk(clk), .in_rst_n(rst_n[1]), .in_start(start[1]),
      .in_pattern(pattern[1][8:0]), .in_autoplay(autoplay[1]),
      .in_game_state(gs[1]), .in_grid(grid[1][8:0]),
      .out_stop(stop[1]), .out_prgm(prgm[1]), .out_pp(pp[1]),
      .out_btn0(btn0[1]), .out_btn1(btn1[1]), .out_busy(busy[1]),
      .out_done(done[1]), .out_error(err[1]), .out_cell_idx(idx[1])
   );

   // Model core: its own cursor advances on every button press.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n[d]) begin
            gs[d] = GS_STOP; grid[d] = '0; cursor[d] = 0;
         end else begin
            if (stop[d]) gs[d] = GS_STOP;
            if (prgm[d]) begin
               gs[d] = ack_en[d] ? GS_PRGM : GS_STOP;
               grid[d] = '0; cursor[d] = 0;
            end
            if ((btn0[d] || btn1[d]) && cursor[d] < 49) begin
               grid[d][cursor[d]] = btn1[d] ^ (corrupt[d] && cursor[d] == 5);
               cursor[d]++;
            end
            if (pp[d]) gs[d] = GS_PLAY;
         end
      end
   end

   function automatic logic [13:0] obs(input int d);
      return {stop[d], prgm[d], pp[d], btn0[d], btn1[d], busy[d], done[d], err[d], idx[d]};
   endfunction

   function automatic int exp_done(input int d, input logic ap, input logic ack, input logic corr);
      int h, n;
      h = (d != 0) ? 3 : 2;
      n = (d != 0) ? 9 : 49;
      if (!ack) return 2 + 2*h + 15;
      if (corr || !ap) return 3 + 2*h + (n - 1) + h + 2;
      return 3 + 2*h + (n - 1) + h + 4;
   endfunction

   // Expected outputs in cycle t after the accepting edge.
   function automatic logic [13:0] exp_vec(input int d, input int t, input logic [48:0] pat,
                                           input logic ap, input logic ack, input logic corr);
      int h, n, f, dn;
      logic [13:0] v;
      h  = (d != 0) ? 3 : 2;
      n  = (d != 0) ? 9 : 49;
      f  = 3 + 2*h;
      dn = exp_done(d, ap, ack, corr);
      v  = '0;
      v[13] = (t >= 1 && t <= h);
      v[12] = (t > h && t <= 2*h);
      v[11] = ack && ap && !corr && (t == dn - 1);
      if (ack && t >= f && t < f + n) begin
         v[10]  = ~pat[t-f];
         v[9]   = pat[t-f];
         v[5:0] = 6'(t - f);
      end
      v[8] = (t < dn);
      v[7] = (t == dn);
      v[6] = (t >= dn) && (!ack || corr);
      return v;
   endfunction

   task automatic run_txn(input int d, input logic [48:0] pat, input logic ap, input logic ack,
                          input logic corr, input logic ign, input int tbl_done,
                          input logic tbl_err, input string name);
      int dn, seen;
      logic [13:0] ov, ev;
      logic [63:0] junk;
      dn = exp_done(d, ap, ack, corr);
      ack_en[d] = ack; corrupt[d] = corr;
      pattern[d] = pat; autoplay[d] = ap; start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0;
      junk = {$urandom(), $urandom()};
      pattern[d] = junk[48:0];
      autoplay[d] = ~ap;
      seen = -1;
      for (int t = 1; t <= dn + 1; t++) begin
         ov = obs(d);
         ev = exp_vec(d, t, pat, ap, ack, corr);
         checks++;
         if (ov !== ev) begin
            errors++;
            $display("FAIL %s t=%0d {stop,prgm,pp,b0,b1,busy,done,err,idx} got=%b want=%b",
                     name, t, ov, ev);
         end
         if (done[d] === 1'b1 && seen < 0) seen = t;
         start[d] = ign && (t == 30 || t == dn);
         if (t <= dn) @(negedge clk);
      end
      start[d] = 1'b0;
      if (tbl_done > 0) begin
         checks++;
         if (seen != tbl_done || err[d] !== tbl_err) begin
            errors++;
            $display("FAIL %s summary done_at=%0d err=%b want done_at=%0d err=%b",
                     name, seen, err[d], tbl_done, tbl_err);
         end
      end
   endtask

   typedef struct {
      int          d;
      logic [48:0] pat;
      logic        ap, ack, corr, ign;
      int          done_at;
      logic        err;
      string       name;
   } vec_t;

   vec_t tbl [9];

   initial begin
      logic [13:0] ov;
      logic [63:0] r64;
      int          found;
      int          d;

      tbl[0] = '{0, 49'h1_0000_0000_0F81, 1, 1, 0, 0, 61, 0, "spec_pat_autoplay"};
      tbl[1] = '{0, 49'h1_FFFF_FFFF_FFFF, 0, 1, 0, 0, 59, 0, "all_ones_noplay"};
      tbl[2] = '{0, 49'h0_0000_0000_0000, 1, 1, 0, 0, 61, 0, "all_zeros_autoplay"};
      tbl[3] = '{0, 49'h1_0000_0000_0F81, 1, 0, 0, 0, 21, 1, "ack_timeout"};
      tbl[4] = '{0, 49'h0_AAAA_5555_1234, 1, 1, 1, 1, 59, 1, "grid_mismatch_ignored_starts"};
      tbl[5] = '{0, 49'h0_0F0F_F0F0_0001, 1, 1, 0, 0, 61, 0, "restart_clears_error"};
      tbl[6] = '{1, 49'h0_0000_0000_01A5, 0, 1, 0, 0, 22, 0, "small_noplay"};
      tbl[7] = '{1, 49'h0_0000_0000_0033, 0, 0, 0, 0, 23, 1, "small_timeout"};
      tbl[8] = '{1, 49'h0_0000_0000_005A, 1, 1, 0, 0, 24, 0, "small_autoplay"};

      rst_n = '0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (obs(i) !== 14'd0) begin
            errors++;
            $display("FAIL reset_state dut=%0d got=%b want=0", i, obs(i));
         end
      end
      rst_n = '1;
      @(negedge clk);

      for (int i = 0; i < 9; i++)
         run_txn(tbl[i].d, tbl[i].pat, tbl[i].ap, tbl[i].ack, tbl[i].corr, tbl[i].ign,
                 tbl[i].done_at, tbl[i].err, tbl[i].name);

      // Reset in the middle of LOAD, at cell 20.
      ack_en[0] = 1'b1; corrupt[0] = 1'b0;
      pattern[0] = 49'h1_0000_0000_0F81; autoplay[0] = 1'b1; start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      found = 0;
      for (int i = 0; i < 100 && found == 0; i++) begin
         if (idx[0] == 6'd20 && (btn0[0] || btn1[0])) found = 1;
         else @(negedge clk);
      end
      checks++;
      if (found == 0) begin
         errors++;
         $display("FAIL reach_cell20 got=not_reached want=reached");
      end
      rst_n[0] = 1'b0;
      @(negedge clk);
      checks++;
      ov = obs(0);
      if (ov !== 14'd0) begin
         errors++;
         $display("FAIL mid_load_reset got=%b want=0", ov);
      end
      rst_n[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         ov = obs(0);
         if (ov !== 14'd0) begin
            errors++;
            $display("FAIL post_reset_quiet cycle=%0d got=%b want=0", i, ov);
         end
      end
      run_txn(0, 49'h0_1357_9BDF_2468, 1, 1, 0, 0, 61, 0, "after_mid_reset");

      // Randomized transactions against the timeline model.
      for (int i = 0; i < 8; i++) begin
         d   = $urandom_range(0, 1);
         r64 = {$urandom(), $urandom()};
         if (d == 1) r64[63:9] = '0;
         run_txn(d, r64[48:0], 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 3) == 0), 1'b0, 0, 1'b0, "random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
